cipher_iter: RTL



---
 rtl/cipher_iter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cipher_iter.sv
// Iterative AES encryption core (AES-128/192/256 via KEY_BITS), one round per clock.
// The key schedule is expanded one word per cycle into a local key store before blocks are accepted.
module cipher_iter #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        pt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ct
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned IW = $clog2(NW);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("cipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {NOKEY, KEXP, READY, ROUND, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Byte b of a 128-bit state lives at [127-8b -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            if (last) begin
                mc[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return mc ^ rk;
    endfunction

    state_e         state_q, state_d;
    logic [IW-1:0]  key_cnt_q, key_cnt_d;
    logic [2:0]     kmod_q, kmod_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     round_q, round_d;
    logic [127:0]   blk_q, blk_d;
    logic           key_ready_q, key_ready_d;
    logic           ready_q, ready_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    key_store_q [NW];

    logic           key_load;
    logic           last_round;
    logic [31:0]    prev_w, old_w, temp_w, kexp_word;
    logic [IW-1:0]  rk_base;
    logic [127:0]   rk;

    assign key_ready = key_ready_q;
    assign in_ready  = ready_q && !key_valid;
    assign out_valid = out_valid_q;
    assign ct        = blk_q;

    // kmod tracks i mod Nk and rcon steps once per Nk words, so no divider is needed.
    always_comb begin
        prev_w = key_store_q[key_cnt_q - IW'(1)];
        old_w  = key_store_q[key_cnt_q - IW'(NK)];
        if (kmod_q == 3'd0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end else begin
            temp_w = prev_w;
        end
        kexp_word = old_w ^ temp_w;
    end

    // round_q is 0 in READY, so the same lookup yields round key 0 for the initial whitening.
    always_comb begin
        rk_base = IW'({round_q, 2'b00});
        rk = {key_store_q[rk_base], key_store_q[rk_base + IW'(1)],
              key_store_q[rk_base + IW'(2)], key_store_q[rk_base + IW'(3)]};
    end

    always_comb begin
        state_d    = state_q;
        key_cnt_d  = key_cnt_q;
        kmod_d     = kmod_q;
        rcon_d     = rcon_q;
        round_d    = round_q;
        blk_d      = blk_q;
        key_load   = key_valid && key_ready_q;
        last_round = (round_q == 4'(NR));
        case (state_q)
            KEXP: begin
                key_cnt_d = key_cnt_q + IW'(1);
                kmod_d    = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
                if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
                if (key_cnt_q == IW'(NW - 1)) state_d = READY;
            end
            READY: begin
                if (in_valid && !key_valid) begin
                    blk_d   = pt ^ rk;
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                blk_d = aes_round(blk_q, rk, last_round);
                if (last_round) begin
                    round_d = 4'd0;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = READY;
            end
            default: ;
        endcase
        if (key_load) begin
            state_d   = KEXP;
            key_cnt_d = IW'(NK);
            kmod_d    = 3'd0;
            rcon_d    = 8'h01;
        end
        key_ready_d = (state_d == NOKEY) || (state_d == READY);
        ready_d     = (state_d == READY);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NOKEY;
            key_cnt_q   <= '0;
            kmod_q      <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            blk_q       <= '0;
            key_ready_q <= 1'b1;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            kmod_q      <= kmod_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            key_ready_q <= key_ready_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int unsigned j = 0; j < NK; j++) begin
                key_store_q[IW'(j)] <= key[KEY_BITS-1-32*j -: 32];
            end
        end else if (state_q == KEXP) begin
            key_store_q[key_cnt_q] <= kexp_word;
        end
    end

endmodule
